alu_share_ctrl: RTL and testbench
=================================

// Module: alu_share_ctrl
// PURPOSE
//  Sequencer/arbiter that shares one alu datapath instance between two requesters (e.g. fetch-side PC adder and
//  execute stage). It accepts operand/opcode requests, drives the ALU input ports, captures the registered result
//  and flags, and returns them to the winning requester with a one-cycle done strobe. Round-robin between ports.
// PARAMETERS
//  DATA_W  32  operand/result width (ALU is 32-bit; only 32 is supported)
//  CTR_W   3   ALU control width (3'b010 add, 3'b110 sub, 3'b001 or, others pass B)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous reset, active low
//  req0/req1    in   1       level request, held high until the port's done strobe
//  a0/a1        in   DATA_W  operand A, sampled only on the grant edge
//  b0/b1        in   DATA_W  operand B, sampled only on the grant edge
//  ctr0/ctr1    in   CTR_W   ALU control, sampled only on the grant edge
//  done0/done1  out  1       one-cycle strobe; result/zero/carrier valid this cycle for that port
//  result       out  DATA_W  captured ALU result (shared by both ports)
//  zero         out  1       captured ALU zero flag
//  carrier      out  1       captured ALU carry flag (bit 32 of sign-extended op)
//  busy         out  1       high in EXEC and DONE
//  alu_a        out  DATA_W  to ALU A
//  alu_b        out  DATA_W  to ALU B
//  alu_ctr      out  CTR_W   to ALU control
//  alu_result   in   DATA_W  from ALU result
//  alu_zero     in   1       from ALU zero
//  alu_carrier  in   1       from ALU carry
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, ptr=0, owner=0, op regs (alu_a/alu_b/alu_ctr)=0, result=0, zero=0,
//   carrier=0, done0=done1=0, busy=0. Reset takes effect immediately, regardless of clk.
//  FSM: IDLE, EXEC, DONE. Edge updates below.
//   IDLE: no req -> stay. One req -> grant it. Both -> grant port ptr. Grant: latch a/b/ctr of winner into
//    op regs, owner=winner, ptr=~winner, -> EXEC.
//   EXEC: alu_* driven from op regs (ALU is combinational). At edge: result/zero/carrier <= alu_*,
//    -> DONE.
//   DONE: done[owner]=1 (combinational from state+owner), busy=1. At edge: if req of the other port (~owner)
//    is high, grant it (same latch rules) -> EXEC; else -> IDLE. The owner's req is ignored in DONE.
//  Latency: req sampled at grant edge E0 -> EXEC during E0..E1 -> done high during E1..E2. Other port
//   back-to-back: its done 2 cycles after the first. Peak throughput 1 op per 2 cycles.
//  Requester contract: drop req at the edge ending its done cycle. If it is still high when the FSM
//   returns to IDLE, it is served again (new op, new done).
//  Operands may change freely after the grant edge; the op regs hold them. alu_* keep last op values
//   while IDLE (no glitching to 0).
//  result/zero/carrier hold until the next EXEC capture; they are valid only while done is high.
//  No arithmetic in this block; widths pass through unchanged. done0 and done1 are never high together.
//  Mid-operation reset: in-flight op dropped, no done issued; a still-held req is re-arbitrated from
//   ptr=0 after release.
// TESTING
//  T1 req0, a0=5, b0=7, ctr0=010 -> alu_a=5/alu_b=7 in EXEC; done0 2 cycles after grant, result=12, zero=0.
//  T2 req1, a1=3, b1=3, ctr1=110 -> done1, result=0, zero=1, carrier=0; done0 stays 0.
//  T3 req0 add 0xFFFFFFFF+0xFFFFFFFF -> result=0xFFFFFFFE, carrier=1; then req0 or 0xF0|0x0F -> 0xFF.
//  T4 req0 and req1 both high after reset -> done0 (port0 op), then done1 exactly 2 cycles later;
//     repeat with both still high -> order alternates 0,1,0,1. Change a0 after grant -> result unaffected.
//  T5 req0 held high through its done -> re-served: second done0 three cycles after the first (DONE->IDLE->EXEC->DONE).
//  T6 assert rst_n=0 during EXEC -> all outputs 0 at once, no done; release with req1 held -> done1 2 cycles after grant.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Two-port round-robin sequencer that time-shares a single combinational ALU.
// Each granted op runs EXEC (ALU evaluates) then DONE (result returned with a one-cycle strobe).
module alu_share_ctrl #(
    parameter int DATA_W = 32,
    parameter int CTR_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] b1,
    input  logic [CTR_W-1:0]  ctr0,
    input  logic [CTR_W-1:0]  ctr1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carrier,
    output logic              busy,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTR_W-1:0]  alu_ctr,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carrier
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                ptr;
    logic                owner;
    logic                grant_en;
    logic                grant_port;
    logic [DATA_W-1:0]   win_a;
    logic [DATA_W-1:0]   win_b;
    logic [CTR_W-1:0]    win_ctr;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [CTR_W-1:0]    op_ctr;
    logic [DATA_W-1:0]   res_q;
    logic                zero_q;
    logic                carrier_q;

    // Arbitration: in DONE only the port that did not just finish may be granted.
    always_comb begin
        grant_en   = 1'b0;
        grant_port = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    grant_en   = 1'b1;
                    grant_port = ptr;
                end else if (req0) begin
                    grant_en   = 1'b1;
                    grant_port = 1'b0;
                end else if (req1) begin
                    grant_en   = 1'b1;
                    grant_port = 1'b1;
                end
            end
            DONE: begin
                if (owner ? req0 : req1) begin
                    grant_en   = 1'b1;
                    grant_port = ~owner;
                end
            end
            default: begin
                grant_en   = 1'b0;
                grant_port = 1'b0;
            end
        endcase
    end

    assign win_a   = grant_port ? a1   : a0;
    assign win_b   = grant_port ? b1   : b0;
    assign win_ctr = grant_port ? ctr1 : ctr0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = grant_en ? EXEC : IDLE;
            EXEC:    state_nxt = DONE;
            DONE:    state_nxt = grant_en ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant edge: latch the winner's operands so the requester may change them freely afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= 1'b0;
            owner  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            op_ctr <= '0;
        end else if (grant_en) begin
            ptr    <= ~grant_port;
            owner  <= grant_port;
            op_a   <= win_a;
            op_b   <= win_b;
            op_ctr <= win_ctr;
        end
    end

    // EXEC edge: capture the ALU outputs; they hold until the next EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q     <= '0;
            zero_q    <= 1'b0;
            carrier_q <= 1'b0;
        end else if (state == EXEC) begin
            res_q     <= alu_result;
            zero_q    <= alu_zero;
            carrier_q <= alu_carrier;
        end
    end

    always_comb begin
        done0 = (state == DONE) && !owner;
        done1 = (state == DONE) &&  owner;
        busy  = (state == EXEC) || (state == DONE);
    end

    assign alu_a   = op_a;
    assign alu_b   = op_b;
    assign alu_ctr = op_ctr;
    assign result  = res_q;
    assign zero    = zero_q;
    assign carrier = carrier_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed vector table, multi-cycle corner sequences,
// and a randomized two-requester run against a transaction-level reference.
module tb_alu_share_ctrl;

    localparam int DATA_W = 32;
    localparam int CTR_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0, req1;
    logic [DATA_W-1:0] a0, a1, b0, b1;
    logic [CTR_W-1:0]  ctr0, ctr1;
    logic              done0, done1;
    logic [DATA_W-1:0] result;
    logic              zero, carrier, busy;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [CTR_W-1:0]  alu_ctr;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero, alu_carrier;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.DATA_W(DATA_W), .CTR_W(CTR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .ctr0(ctr0), .ctr1(ctr1),
        .done0(done0), .done1(done1),
        .result(result), .zero(zero), .carrier(carrier), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carrier(alu_carrier)
    );

    // ALU behaviour: returns {carry, zero, result}
    function automatic logic [33:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        logic [32:0] ea, eb, r;
        ea = {a[31], a};
        eb = {b[31], b};
        case (c)
            3'b010:  r = ea + eb;
            3'b110:  r = ea - eb;
            3'b001:  r = ea | eb;
            default: r = eb;
        endcase
        return {r[32], (r[31:0] == 32'd0), r[31:0]};
    endfunction

    assign {alu_carrier, alu_zero, alu_result} = alu_fn(alu_a, alu_b, alu_ctr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outs(input string nm);
        chk($sformatf("%s_done", nm), {done1, done0}, 2'b00);
        chk($sformatf("%s_busy", nm), busy, 1'b0);
        chk($sformatf("%s_result", nm), result, 32'd0);
        chk($sformatf("%s_flags", nm), {zero, carrier}, 2'b00);
        chk($sformatf("%s_alu_ops", nm), {alu_a, alu_b, alu_ctr}, 67'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_zero_outs("reset");
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        port;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctr;
        logic [31:0] res;
        logic        z;
        logic        c;
    } vec_t;

    vec_t vt[7];

    task automatic serve_one(input vec_t v, input string nm);
        int lat;
        lat = 0;
        if (!v.port) begin
            req0 = 1'b1; a0 = v.a; b0 = v.b; ctr0 = v.ctr;
        end else begin
            req1 = 1'b1; a1 = v.a; b1 = v.b; ctr1 = v.ctr;
        end
        while (!(done0 || done1) && lat < 10) begin
            tick();
            lat++;
        end
        chk($sformatf("%s_latency", nm), lat, 2);
        chk($sformatf("%s_port", nm), {done1, done0}, v.port ? 2'b10 : 2'b01);
        chk($sformatf("%s_result", nm), result, v.res);
        chk($sformatf("%s_zero", nm), zero, v.z);
        chk($sformatf("%s_carrier", nm), carrier, v.c);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        chk($sformatf("%s_idle", nm), {busy, done1, done0}, 3'b000);
    endtask

    // Randomized requester state
    logic        pend[2];
    logic [31:0] ra[2], rb[2];
    logic [2:0]  rc[2];
    int          age[2];
    int          must_next;

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [2:0] rnd_ctr();
        case ($urandom_range(0, 4))
            0:       return 3'b010;
            1:       return 3'b110;
            2:       return 3'b001;
            3:       return 3'(($urandom_range(0, 7)));
            default: return 3'b010;
        endcase
    endfunction

    task automatic drive_port(input int p, input logic r);
        if (p == 0) begin
            req0 = r; a0 = ra[0]; b0 = rb[0]; ctr0 = rc[0];
        end else begin
            req1 = r; a1 = ra[1]; b1 = rb[1]; ctr1 = rc[1];
        end
    endtask

    initial begin
        logic [1:0]  exp_d;
        logic [31:0] exp_r;
        logic [33:0] ref_v;
        logic [1:0]  d;
        logic        just_done[2];
        int          lat;

        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0; ctr0 = '0; ctr1 = '0;

        vt[0] = '{1'b0, 32'd5,          32'd7,          3'b010, 32'd12,         1'b0, 1'b0};
        vt[1] = '{1'b1, 32'd3,          32'd3,          3'b110, 32'd0,          1'b1, 1'b0};
        vt[2] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  3'b010, 32'hFFFF_FFFE,  1'b0, 1'b1};
        vt[3] = '{1'b0, 32'h0000_00F0,  32'h0000_000F,  3'b001, 32'h0000_00FF,  1'b0, 1'b0};
        vt[4] = '{1'b1, 32'd1,          32'h8000_0000,  3'b111, 32'h8000_0000,  1'b0, 1'b1};
        vt[5] = '{1'b1, 32'd5,          32'd7,          3'b110, 32'hFFFF_FFFE,  1'b0, 1'b1};
        vt[6] = '{1'b0, 32'h1234,       32'd0,          3'b000, 32'd0,          1'b1, 1'b0};

        do_reset();

        // T1 with EXEC-phase visibility and operand change after grant
        req0 = 1'b1; a0 = 32'd5; b0 = 32'd7; ctr0 = 3'b010;
        tick();
        chk("t1_exec_ops", {alu_a, alu_b, alu_ctr}, {32'd5, 32'd7, 3'b010});
        chk("t1_exec_busy", {busy, done1, done0}, 3'b100);
        a0 = 32'd99;
        tick();
        chk("t1_done", {done1, done0}, 2'b01);
        chk("t1_result", result, 32'd12);
        chk("t1_zero", zero, 1'b0);
        req0 = 1'b0;
        tick();
        chk("t1_idle_busy", busy, 1'b0);
        chk("t1_idle_hold_ops", {alu_a, alu_b, alu_ctr}, {32'd5, 32'd7, 3'b010});

        for (int i = 0; i < 7; i++) serve_one(vt[i], $sformatf("vec%0d", i));

        // T4: both requesting after reset, held -> alternation 0,1,0,1
        do_reset();
        req0 = 1'b1; a0 = 32'd10; b0 = 32'd1; ctr0 = 3'b010;
        req1 = 1'b1; a1 = 32'd20; b1 = 32'd2; ctr1 = 3'b110;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) a0 = 32'd100;
            exp_d = 2'b00;
            exp_r = 32'd0;
            case (i)
                2: begin exp_d = 2'b01; exp_r = 32'd11;  end
                4: begin exp_d = 2'b10; exp_r = 32'd18;  end
                6: begin exp_d = 2'b01; exp_r = 32'd101; end
                8: begin exp_d = 2'b10; exp_r = 32'd18;  end
                default: ;
            endcase
            chk($sformatf("t4_done_c%0d", i), {done1, done0}, exp_d);
            if (exp_d != 2'b00) chk($sformatf("t4_result_c%0d", i), result, exp_r);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("t4_idle", busy, 1'b0);

        // T5: req0 held through done -> re-served three cycles later
        req0 = 1'b1; a0 = 32'd1; b0 = 32'd2; ctr0 = 3'b010;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 2) begin
                chk("t5_first_result", result, 32'd3);
                a0 = 32'd4;
            end
            chk($sformatf("t5_done_c%0d", i), done0, (i == 2 || i == 5));
        end
        chk("t5_second_result", result, 32'd6);
        req0 = 1'b0;
        tick();
        chk("t5_idle", busy, 1'b0);

        // T6: reset during EXEC, req1 still held afterwards
        req1 = 1'b1; a1 = 32'd8; b1 = 32'd8; ctr1 = 3'b010;
        tick();
        chk("t6_exec_busy", busy, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero_outs("t6_async");
        tick();
        chk("t6_no_done", {done1, done0}, 2'b00);
        tick();
        rst_n = 1'b1;
        lat = 0;
        while (!(done0 || done1) && lat < 10) begin
            tick();
            lat++;
        end
        chk("t6_latency", lat, 2);
        chk("t6_port", {done1, done0}, 2'b10);
        chk("t6_result", result, 32'd16);
        req1 = 1'b0;
        tick();

        // Randomized two-requester run
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; age[p] = 0; ra[p] = '0; rb[p] = '0; rc[p] = '0;
        end
        must_next = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            d = {done1, done0};
            chk("rnd_exclusive", (d == 2'b11), 1'b0);
            for (int p = 0; p < 2; p++) begin
                just_done[p] = 1'b0;
                if (pend[p]) age[p]++;
            end
            for (int p = 0; p < 2; p++) begin
                if (d[p]) begin
                    chk($sformatf("rnd_pending_p%0d", p), pend[p], 1'b1);
                    ref_v = alu_fn(ra[p], rb[p], rc[p]);
                    chk($sformatf("rnd_out_p%0d", p), {carrier, zero, result}, ref_v);
                    chk("rnd_busy", busy, 1'b1);
                    chk($sformatf("rnd_latency_p%0d", p), (age[p] >= 2 && age[p] <= 6), 1'b1);
                    if (must_next >= 0) chk("rnd_round_robin", p, must_next);
                    must_next = pend[1-p] ? (1 - p) : -1;
                    pend[p] = 1'b0;
                    just_done[p] = 1'b1;
                    drive_port(p, 1'b0);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && age[p] > 12) begin
                    chk($sformatf("rnd_timeout_p%0d", p), age[p], 0);
                    pend[p] = 1'b0;
                    must_next = -1;
                    drive_port(p, 1'b0);
                end else if (!pend[p] && !just_done[p] && $urandom_range(0, 2) == 0) begin
                    ra[p] = rnd_word();
                    rb[p] = ($urandom_range(0, 5) == 0) ? ra[p] : rnd_word();
                    rc[p] = rnd_ctr();
                    pend[p] = 1'b1;
                    age[p] = 0;
                    drive_port(p, 1'b1);
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (6) tick();
        chk("end_idle", {busy, done1, done0}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
